nios_hps_system_uart_tx_hw: RTL and testbench
=============================================

Name: nios_hps_system_uart_tx_hw

Overview:
- Hardware UART transmitter on the Nios Avalon-MM bus; complements the bit-banged polled RX input port.
- Software writes a byte and the block serialises it on out_port: 8N1, LSB first, programmable bit period.
- Status and divisor registers are readable with one-cycle registered read latency, matching the existing PIO slaves.

Parameters:
- DIV_WIDTH, 16, width of the bit-period divisor register.
- DIV_RESET, 433, reset divisor value; bit period = divisor+1 clocks (50 MHz / 115200).

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- address  in  2  register select: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 reserved.
- chipselect  in  1  slave select, qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- out_port  out  1  serial TX line, idle high.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - out_port=1, readdata=0, busy=0, overrun=0, divisor=DIV_RESET, last-data=0, state=IDLE.
  - A frame in flight is abandoned immediately; the line returns high on the next edge.
- Write strobe: chipselect=1 and write_n=0 at a clk edge. Writes to address 3 are ignored.
- TXDATA write (address 0), busy=0:
  - Latch writedata[7:0] into the shift register and last-data.
  - Latch the divisor into a per-frame working copy.
  - Set busy and enter START.
  - out_port drives 0 from the next edge (1-cycle latency).
- TXDATA write while busy=1:
  - Data is dropped and the frame in flight is unaffected.
  - overrun is set (sticky).
- FSM states IDLE -> START -> DATA -> STOP -> IDLE. Each state holds its bit for exactly workdiv+1 clocks, timed by a down-counter.
  - START: out_port=0.
  - DATA: out_port=shift[0]; shift right after each bit; 8 bits counted by a 3-bit index.
  - STOP: out_port=1; at the end of the bit, busy clears and the state returns to IDLE.
- Frame length: exactly 10*(workdiv+1) clocks from the first low cycle to busy falling.
- Divisor 0 is legal: 1 clock per bit, 10-clock frame.
- Back-to-back frames:
  - busy falls on the last STOP clock edge.
  - A TXDATA write on that same edge still sees busy=1, so the data is dropped and overrun is set.
  - A write on the next edge or later starts a new frame normally.
- STATUS write (address 1): writedata[1]=1 clears overrun; all other bits are ignored. If an overrun event and the clear occur on the same edge, set wins.
- DIVISOR write (address 2):
  - Updates divisor from writedata[DIV_WIDTH-1:0] at any time.
  - A frame in flight keeps its working copy; the new value applies from the next frame.
- Reads: readdata is registered every clk edge, independent of chipselect; unused bits are 0.
  - Address 0: {24'b0, last-data}.
  - Address 1: {30'b0, overrun, busy}.
  - Address 2: zero-extended divisor.
  - Address 3: 0.
- No irq; software polls busy.

Test Plan:
- Reset, then idle 20 clks -> out_port=1, readdata=0; read address 2 -> 433 one cycle after the address is applied.
- Write DIVISOR=3, then TXDATA=0xA5 -> out_port holds each bit for 4 clks:
  - Sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - busy=1 for 40 clks, then 0.
- Divisor 0, TXDATA=0x00 -> start plus 8 data bits give 9 consecutive low clks, then 1 high clk; busy clears after 10 clks.
- Overrun case, divisor 3:
  - Write 0x55, then write 0x0F mid-frame -> wire still shows 0x55 only; STATUS reads 0x3.
  - Write STATUS with bit1=1 -> STATUS reads 0x0.
  - Write on the exact busy-falling edge -> dropped, overrun=1.
- Mid-frame DIVISOR change 3->7 during 0xFF -> current frame keeps 4-clk bits; the next frame uses 8-clk bits (80-clk frame).
- Assert reset_n=0 for 1 clk during the DATA state -> out_port=1 and busy=0 the next cycle; a new TXDATA write transmits correctly with divisor=433.

Source files
------------

// File: rtl/nios_hps_system_uart_tx_hw_if.sv
// Avalon-MM slave bus bundle for the hardware UART transmitter.
// The master side drives address/strobes/data; the slave side returns registered readdata.
interface nios_hps_system_uart_tx_hw_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_hps_system_uart_tx_hw.sv
// Avalon-MM UART transmitter: 8N1, LSB first, bit period = divisor+1 clocks.
// Registers: 0 TXDATA, 1 STATUS {overrun, busy}, 2 DIVISOR; reads are registered.
module nios_hps_system_uart_tx_hw #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_RESET = 433
) (
  input  logic                         clk,
  input  logic                         reset_n,
  nios_hps_system_uart_tx_hw_if.slave  avs,
  output logic                         out_port
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic                 busy;
  logic                 overrun;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] workdiv;
  logic [DIV_WIDTH-1:0] cnt;
  logic [7:0]           last_data;
  logic [7:0]           shift;
  logic [2:0]           bit_idx;
  logic [31:0]          rdata;

  logic wr_strobe;
  logic wr_tx;
  logic wr_stat;
  logic wr_div;
  logic unused_wdata;

  assign wr_strobe    = avs.chipselect && !avs.write_n;
  assign wr_tx        = wr_strobe && (avs.address == 2'd0);
  assign wr_stat      = wr_strobe && (avs.address == 2'd1);
  assign wr_div       = wr_strobe && (avs.address == 2'd2);
  assign unused_wdata = ^avs.writedata;
  assign avs.readdata = rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      divisor   <= DIV_WIDTH'(DIV_RESET);
      workdiv   <= '0;
      cnt       <= '0;
      last_data <= 8'd0;
      shift     <= 8'd0;
      bit_idx   <= 3'd0;
      out_port  <= 1'b1;
      rdata     <= 32'd0;
    end else begin
      // Read path samples pre-edge register values, independent of chipselect.
      case (avs.address)
        2'd0:    rdata <= {24'd0, last_data};
        2'd1:    rdata <= {30'd0, overrun, busy};
        2'd2:    rdata <= 32'(divisor);
        default: rdata <= 32'd0;
      endcase

      if (wr_div)
        divisor <= avs.writedata[DIV_WIDTH-1:0];

      // A dropped TXDATA write takes priority over a same-edge clear.
      if (wr_tx && busy)
        overrun <= 1'b1;
      else if (wr_stat && avs.writedata[1])
        overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (wr_tx) begin
            shift     <= avs.writedata[7:0];
            last_data <= avs.writedata[7:0];
            workdiv   <= divisor;
            cnt       <= divisor;
            bit_idx   <= 3'd0;
            busy      <= 1'b1;
            out_port  <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt      <= workdiv;
            out_port <= shift[0];
            state    <= DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt     <= workdiv;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              out_port <= 1'b1;
              state    <= STOP;
            end else begin
              out_port <= shift[1];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_hps_system_uart_tx_hw.sv
// Directed plus randomized bench for the Avalon-MM UART transmitter.
// Expected wire levels come from the 8N1 frame definition evaluated per clock.
module tb_nios_hps_system_uart_tx_hw;

  logic clk;
  logic reset_n;
  logic out_port;

  nios_hps_system_uart_tx_hw_if bus_if();

  nios_hps_system_uart_tx_hw #(
    .DIV_WIDTH (16),
    .DIV_RESET (433)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus_if),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          div_model;
  logic        ovr_model;
  logic [7:0]  last_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Line level k clocks after the first low cycle of a frame with bit period d+1.
  function automatic logic exp_bit(input logic [7:0] data, input int d, input int k);
    int b;
    b = k / (d + 1);
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return data[b-1];
  endfunction

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] wd);
    bus_if.address    = addr;
    bus_if.writedata  = wd;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    if (addr == 2'd2) div_model = int'(wd[15:0]);
    if (addr == 2'd1 && wd[1]) ovr_model = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] addr, input string tag, input logic [31:0] exp);
    bus_if.address = addr;
    tick();
    check(tag, bus_if.readdata, exp);
  endtask

  // Send one frame and check every clock of it; optionally inject one write at clock mid_at.
  task automatic send_frame(input logic [7:0] data, input int mid_at,
                            input logic [1:0] mid_addr, input logic [31:0] mid_data);
    int d;
    int n;
    d = div_model;
    n = 10 * (d + 1);
    write_reg(2'd0, {24'd0, data});
    last_model = data;
    bus_if.address = 2'd1;
    for (int k = 0; k < n; k++) begin
      if (mid_at >= 0 && mid_addr == 2'd0 && k == mid_at + 2) ovr_model = 1'b1;
      check("wire", {31'd0, out_port}, {31'd0, exp_bit(data, d, k)});
      if (mid_at >= 0 && k == mid_at + 1) begin
        if (mid_addr == 2'd0) check("drop", bus_if.readdata, {24'd0, data});
      end else if (k >= 1) begin
        check("status_busy", bus_if.readdata, {30'd0, ovr_model, 1'b1});
      end
      if (k == mid_at) begin
        bus_if.address    = mid_addr;
        bus_if.writedata  = mid_data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
      end
      tick();
      if (k == mid_at) begin
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd1;
        if (mid_addr == 2'd2) div_model = int'(mid_data[15:0]);
      end
    end
    if (mid_at >= 0 && mid_addr == 2'd0) ovr_model = 1'b1;
    check("stop_high", {31'd0, out_port}, 32'd1);
    tick();
    check("idle_high", {31'd0, out_port}, 32'd1);
    check("status_idle", bus_if.readdata, {30'd0, ovr_model, 1'b0});
  endtask

  initial begin
    logic [7:0] rdat;
    int         rdiv;
    int         rmid;

    checks = 0;
    errors = 0;
    div_model  = 433;
    ovr_model  = 1'b0;
    last_model = 8'd0;
    reset_n           = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;

    // Reset and idle
    tick(); tick();
    check("rst_out", {31'd0, out_port}, 32'd1);
    check("rst_rd", bus_if.readdata, 32'd0);
    reset_n = 1'b1;
    repeat (20) tick();
    check("idle_out", {31'd0, out_port}, 32'd1);
    check("idle_rd", bus_if.readdata, 32'd0);
    read_reg(2'd2, "div_reset", 32'd433);
    read_reg(2'd1, "status_reset", 32'd0);

    // Divisor 3, 0xA5: ten 4-clock bits
    write_reg(2'd2, 32'd3);
    read_reg(2'd2, "div_3", 32'd3);
    send_frame(8'hA5, -1, 2'd0, 32'd0);
    read_reg(2'd0, "last_a5", 32'h0000_00A5);

    // Divisor 0, 0x00: nine low clocks then one high
    write_reg(2'd2, 32'd0);
    send_frame(8'h00, -1, 2'd0, 32'd0);

    // Overrun mid-frame, then clear
    write_reg(2'd2, 32'd3);
    send_frame(8'h55, 13, 2'd0, 32'h0000_000F);
    read_reg(2'd0, "last_55", 32'h0000_0055);
    write_reg(2'd1, 32'd2);
    read_reg(2'd1, "status_clr", 32'd0);

    // Write landing on the busy-falling edge is dropped
    send_frame(8'h96, 39, 2'd0, 32'h0000_0033);
    read_reg(2'd1, "status_edge", 32'd2);
    read_reg(2'd0, "last_96", 32'h0000_0096);
    write_reg(2'd1, 32'd2);
    read_reg(2'd1, "status_clr2", 32'd0);

    // Divisor change mid-frame applies to the next frame only
    send_frame(8'hFF, 17, 2'd2, 32'd7);
    read_reg(2'd2, "div_7", 32'd7);
    send_frame(8'h81, -1, 2'd0, 32'd0);

    // Randomized frames with occasional overrun injection
    for (int i = 0; i < 8; i++) begin
      rdiv = int'($urandom_range(0, 7));
      rdat = 8'($urandom_range(0, 255));
      write_reg(2'd2, 32'(rdiv));
      if ($urandom_range(0, 2) == 0)
        rmid = int'($urandom_range(0, 10 * (rdiv + 1) - 1));
      else
        rmid = -1;
      send_frame(rdat, rmid, 2'd0, 32'($urandom_range(0, 255)));
      read_reg(2'd0, "rnd_last", {24'd0, last_model});
      if (ovr_model) begin
        write_reg(2'd1, 32'd2);
        read_reg(2'd1, "rnd_clr", 32'd0);
      end
    end

    // Reset during DATA abandons the frame
    write_reg(2'd2, 32'd3);
    write_reg(2'd0, 32'h0000_003C);
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    div_model  = 433;
    ovr_model  = 1'b0;
    last_model = 8'd0;
    check("rst_mid_out", {31'd0, out_port}, 32'd1);
    read_reg(2'd1, "rst_mid_status", 32'd0);
    check("rst_mid_out2", {31'd0, out_port}, 32'd1);
    read_reg(2'd2, "rst_mid_div", 32'd433);
    read_reg(2'd0, "rst_mid_last", 32'd0);
    rdat = 8'($urandom_range(0, 255));
    send_frame(rdat, -1, 2'd0, 32'd0);
    read_reg(2'd0, "post_rst_last", {24'd0, rdat});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
